// File: rtl/striping_scheduler.sv
// Lane-select controller for the two-lane striping demux: retimes each word with
// its selector, round-robins between enabled lanes and keeps per-lane word counts.
module striping_scheduler #(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic [1:0]        lane_en,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              selector,
  output logic [CNT_W-1:0]  cnt_lane0,
  output logic [CNT_W-1:0]  cnt_lane1,
  output logic              drop_err,
  output logic              aligned
);

  typedef enum logic [1:0] {IDLE, NEXT0, NEXT1} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] idle_cnt, idle_nxt;
  logic       pref, lane, dispatch, drop, timeout;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // paths that skip an assignment infer latches.
  always_comb begin
    pref     = (state == NEXT1);
    lane     = pref;
    dispatch = 1'b0;
    drop     = 1'b0;
    if (valid_in) begin
      if (lane_en[pref]) begin
        dispatch = 1'b1;
      end else if (lane_en[~pref]) begin
        lane     = ~pref;
        dispatch = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    timeout = (state != IDLE) && !valid_in && (idle_cnt == TIMEOUT_LAST);

    state_nxt = state;
    idle_nxt  = idle_cnt;
    if (flush) begin
      state_nxt = IDLE;
      idle_nxt  = '0;
    end else if (dispatch) begin
      state_nxt = lane ? NEXT0 : NEXT1;
      idle_nxt  = '0;
    end else if (drop) begin
      idle_nxt = '0;
    end else if (timeout) begin
      state_nxt = IDLE;
      idle_nxt  = '0;
    end else if (state != IDLE) begin
      idle_nxt = idle_cnt + 8'd1;
    end else begin
      idle_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  always_comb begin
    aligned = (state == IDLE);
  end

  // Datapath: a dropped or idle cycle zeroes the word but leaves the selector parked.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      selector  <= 1'b0;
      drop_err  <= 1'b0;
      cnt_lane0 <= '0;
      cnt_lane1 <= '0;
    end else begin
      data_out  <= dispatch ? data_in : '0;
      valid_out <= dispatch;
      drop_err  <= drop;
      if (dispatch) selector <= lane;
      if (flush) begin
        cnt_lane0 <= '0;
        cnt_lane1 <= '0;
      end else if (dispatch) begin
        if (lane) cnt_lane1 <= cnt_lane1 + CNT_W'(1);
        else      cnt_lane0 <= cnt_lane0 + CNT_W'(1);
      end
    end
  end

endmodule
